// File: rtl/rv32c_compress_packer.sv
// Compresses eligible RV32I instructions to 16-bit RVC parcels and packs the parcel stream
// little-endian into 32-bit words. Define RV32C_PACK_STATS_EN to add saturating counters.
module rv32c_compress_packer #(
    parameter int unsigned COMPRESS = 1
`ifdef RV32C_PACK_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_last,
    output logic        pending
`ifdef RV32C_PACK_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_total,
    output logic [CNT_W-1:0] stat_compressed
`endif
);

    localparam bit COMPRESS_EN = (COMPRESS != 0);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_PAD   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_word_q, out_word_d;
    logic        out_last_q, out_last_d;
    logic        pending_q;

    logic        out_stall;
    logic        in_accept;

    // Instruction field extraction
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm_i, imm_s;
    logic        imm_i_6bit;
    logic        rvc_match;
    logic [15:0] rvc_parcel;
    logic        is_c;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];
    assign imm_i  = in_instr[31:20];
    assign imm_s  = {in_instr[31:25], in_instr[11:7]};

    // imm fits the signed 6-bit RVC range [-32,31] when bits 11..5 are a pure sign extension
    assign imm_i_6bit = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7F);

    always_comb begin
        rvc_match  = 1'b0;
        rvc_parcel = 16'h0000;
        if (opcode == 7'b0010011 && funct3 == 3'b000) begin
            if (rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd0) begin
                rvc_match  = 1'b1;
                rvc_parcel = 16'h0001;
            end else if (rd != 5'd0 && rs1 == rd && imm_i != 12'd0 && imm_i_6bit) begin
                rvc_match  = 1'b1;
                rvc_parcel = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            end else if (rd != 5'd0 && rs1 == 5'd0 && imm_i_6bit) begin
                rvc_match  = 1'b1;
                rvc_parcel = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
            end
        end else if (opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'd0 &&
                     rd != 5'd0 && rs2 != 5'd0) begin
            if (rs1 == 5'd0) begin
                rvc_match  = 1'b1;
                rvc_parcel = {4'b1000, rd, rs2, 2'b10};
            end else if (rs1 == rd) begin
                rvc_match  = 1'b1;
                rvc_parcel = {4'b1001, rd, rs2, 2'b10};
            end
        end else if (opcode == 7'b0000011 && funct3 == 3'b010 && rd[4:3] == 2'b01 &&
                     rs1[4:3] == 2'b01 && imm_i[1:0] == 2'b00 && imm_i[11:7] == 5'd0) begin
            rvc_match  = 1'b1;
            rvc_parcel = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end else if (opcode == 7'b0100011 && funct3 == 3'b010 && rs2[4:3] == 2'b01 &&
                     rs1[4:3] == 2'b01 && imm_s[1:0] == 2'b00 && imm_s[11:7] == 5'd0) begin
            rvc_match  = 1'b1;
            rvc_parcel = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end
    end

    assign is_c      = COMPRESS_EN && rvc_match;
    assign out_stall = out_valid_q && !out_ready;
    assign in_ready  = !out_stall && (state_q != ST_PAD);
    assign in_accept = in_valid && in_ready;

    // Next-state and output-stage logic
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q && !out_ready;
        out_word_d  = out_word_q;
        out_last_d  = out_last_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_accept) begin
                    if (is_c) begin
                        hold_d  = rvc_parcel;
                        state_d = in_last ? ST_PAD : ST_HALF;
                    end else begin
                        out_valid_d = 1'b1;
                        out_word_d  = in_instr;
                        out_last_d  = in_last;
                    end
                end
            end
            ST_HALF: begin
                if (in_accept) begin
                    out_valid_d = 1'b1;
                    if (is_c) begin
                        out_word_d = {rvc_parcel, hold_q};
                        out_last_d = in_last;
                        state_d    = ST_EMPTY;
                    end else begin
                        out_word_d = {in_instr[15:0], hold_q};
                        out_last_d = 1'b0;
                        hold_d     = in_instr[31:16];
                        state_d    = in_last ? ST_PAD : ST_HALF;
                    end
                end
            end
            ST_PAD: begin
                if (!out_stall) begin
                    out_valid_d = 1'b1;
                    out_word_d  = {16'h0001, hold_q};
                    out_last_d  = 1'b1;
                    state_d     = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            hold_q      <= 16'h0000;
            out_valid_q <= 1'b0;
            out_word_q  <= 32'h0000_0000;
            out_last_q  <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_last_q  <= out_last_d;
            pending_q   <= (state_d != ST_EMPTY);
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_last  = out_last_q;
    assign pending   = pending_q;

`ifdef RV32C_PACK_STATS_EN
    logic [CNT_W-1:0] total_q, comp_q;

    // Saturating counters of accepted and compressed instructions
    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
            comp_q  <= '0;
        end else if (in_accept) begin
            if (total_q != '1) total_q <= total_q + CNT_W'(1);
            if (is_c && comp_q != '1) comp_q <= comp_q + CNT_W'(1);
        end
    end

    assign stat_total      = total_q;
    assign stat_compressed = comp_q;
`endif

endmodule

// File: tb/tb_rv32c_compress_packer.sv
// Randomized bench for rv32c_compress_packer against a halfword-stream reference model.
module tb_rv32c_compress_packer;

    localparam int unsigned TB_COMPRESS = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;
    logic        pending;
`ifdef RV32C_PACK_STATS_EN
    logic [15:0] stat_total;
    logic [15:0] stat_compressed;
`endif

    always #5 clk = ~clk;

    rv32c_compress_packer #(.COMPRESS(TB_COMPRESS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last),
        .pending   (pending)
`ifdef RV32C_PACK_STATS_EN
        ,
        .stat_total      (stat_total),
        .stat_compressed (stat_compressed)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int ready_pct = 100;
    int m_total = 0;
    int m_comp  = 0;

    logic [15:0] blk_q[$];
    logic [31:0] expw_q[$];
    logic        expl_q[$];
    logic [32:0] got_q[$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference compression from the instruction-set rules, using integer arithmetic
    function automatic void m_compress(input logic [31:0] i, output bit is_c, output logic [15:0] h);
        int op, rd, f3, rs1, rs2, f7, immi, imms;
        op   = int'(i[6:0]);
        rd   = int'(i[11:7]);
        f3   = int'(i[14:12]);
        rs1  = int'(i[19:15]);
        rs2  = int'(i[24:20]);
        f7   = int'(i[31:25]);
        immi = int'($signed(i[31:20]));
        imms = int'($signed({i[31:25], i[11:7]}));
        is_c = 1'b0;
        h    = 16'h0;
        if (op == 19 && f3 == 0) begin
            if (rd == 0 && rs1 == 0 && immi == 0) begin
                is_c = 1'b1; h = 16'h0001;
            end else if (rd != 0 && rs1 == rd && immi != 0 && immi >= -32 && immi <= 31) begin
                is_c = 1'b1; h = 16'(((immi >> 5) & 1) * 4096 + rd * 128 + (immi & 31) * 4 + 1);
            end else if (rd != 0 && rs1 == 0 && immi >= -32 && immi <= 31) begin
                is_c = 1'b1; h = 16'(2 * 8192 + ((immi >> 5) & 1) * 4096 + rd * 128 + (immi & 31) * 4 + 1);
            end
        end else if (op == 51 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0) begin
            if (rs1 == 0) begin
                is_c = 1'b1; h = 16'(8 * 4096 + rd * 128 + rs2 * 4 + 2);
            end else if (rs1 == rd) begin
                is_c = 1'b1; h = 16'(9 * 4096 + rd * 128 + rs2 * 4 + 2);
            end
        end else if (op == 3 && f3 == 2 && rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 &&
                     immi >= 0 && immi <= 124 && immi % 4 == 0) begin
            is_c = 1'b1;
            h = 16'(2 * 8192 + ((immi / 8) % 8) * 1024 + (rs1 - 8) * 128 + ((immi / 4) % 2) * 64 +
                    (immi / 64) * 32 + (rd - 8) * 4);
        end else if (op == 35 && f3 == 2 && rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15 &&
                     imms >= 0 && imms <= 124 && imms % 4 == 0) begin
            is_c = 1'b1;
            h = 16'(6 * 8192 + ((imms / 8) % 8) * 1024 + (rs1 - 8) * 128 + ((imms / 4) % 2) * 64 +
                    (imms / 64) * 32 + (rs2 - 8) * 4);
        end
        if (TB_COMPRESS == 0) is_c = 1'b0;
    endfunction

    // Block-level packing: halfword list, padded with C.NOP when a block ends odd
    function automatic void model_accept(input logic [31:0] i, input logic last);
        bit          c;
        logic [15:0] h, lo, hi;
        m_compress(i, c, h);
        if (c) blk_q.push_back(h);
        else begin
            blk_q.push_back(i[15:0]);
            blk_q.push_back(i[31:16]);
        end
        if (m_total < 65535) m_total++;
        if (c && m_comp < 65535) m_comp++;
        if (last && (blk_q.size() % 2 == 1)) blk_q.push_back(16'h0001);
        while (blk_q.size() >= 2) begin
            lo = blk_q.pop_front();
            hi = blk_q.pop_front();
            expw_q.push_back({hi, lo});
            expl_q.push_back(last && blk_q.size() == 0);
        end
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 64'(out_valid), 64'd1);
                check_eq("stall_word", 64'({out_last, out_word}), 64'(prev_word));
            end
            if (out_valid && !out_ready) check_eq("stall_in_ready", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_word});
                if (expw_q.size() == 0) check_eq("unexpected_word", 64'(out_word), 64'hDEAD_BEEF_0000_0000);
                else begin
                    check_eq("word", 64'(out_word), 64'(expw_q.pop_front()));
                    check_eq("last", 64'(out_last), 64'(expl_q.pop_front()));
                end
            end
            if (in_valid && in_ready) model_accept(in_instr, in_last);
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_word};
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (int'($urandom_range(99)) < ready_pct);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] instr, input logic last);
        logic got;
        int   cyc;
        in_valid = 1'b1;
        in_instr = instr;
        in_last  = last;
        got      = 1'b0;
        cyc      = 0;
        while (!got && cyc < 500) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!got) check_eq("send_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while ((expw_q.size() != 0 || in_valid || pending || out_valid) && cyc < 1000) begin
            idle(1);
            cyc++;
        end
        check_eq("drain_queue", 64'(expw_q.size()), 64'd0);
        check_eq("drain_pending", 64'(pending), 64'd0);
`ifdef RV32C_PACK_STATS_EN
        check_eq("stat_total", 64'(stat_total), 64'(m_total));
        check_eq("stat_compressed", 64'(stat_compressed), 64'(m_comp));
`endif
    endtask

    task automatic clear_model();
        blk_q.delete();
        expw_q.delete();
        expl_q.delete();
        m_total = 0;
        m_comp  = 0;
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        idle(n);
        reset = 1'b0;
        clear_model();
    endtask

    function automatic logic [31:0] rand_instr();
        int          k, v;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        k   = int'($urandom_range(7));
        rd  = 5'($urandom_range(31));
        rs2 = 5'($urandom_range(31));
        v   = int'($urandom_range(80)) - 40;
        imm = 12'(v);
        case (k)
            0: return {imm, rd, 3'b000, rd, 7'h13};
            1: return {imm, 5'd0, 3'b000, rd, 7'h13};
            2: begin
                rs1 = ($urandom_range(1) == 0) ? 5'd0 : rd;
                return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
            end
            3: begin
                rd  = 5'($urandom_range(17, 6));
                rs1 = 5'($urandom_range(17, 6));
                imm = 12'($urandom_range(130));
                return {imm, rs1, 3'b010, rd, 7'h03};
            end
            4: begin
                rs2 = 5'($urandom_range(17, 6));
                rs1 = 5'($urandom_range(17, 6));
                imm = 12'($urandom_range(130));
                return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            end
            5: return $urandom;
            6: return 32'h0000_0013;
            default: return {20'($urandom), rd, 7'h37};
        endcase
    endfunction

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_word", 64'(out_word), 64'd0);
        check_eq("rst_out_last", 64'(out_last), 64'd0);
        check_eq("rst_pending", 64'(pending), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        // Mixed compressed / 32-bit block
        got_q.delete();
        send(32'h0032_8293, 1'b0);
        send(32'h1234_50B7, 1'b0);
        send(32'h00B5_0533, 1'b1);
        drain();
        check_eq("mix_count", 64'(got_q.size()), 64'd2);
        check_eq("mix_w0", 64'(got_q[0]), 64'({1'b0, 32'h50B7_028D}));
        check_eq("mix_w1", 64'(got_q[1]), 64'({1'b1, 32'h952E_1234}));

        // Lone C.NOP block gets padded
        got_q.delete();
        send(32'h0000_0013, 1'b1);
        drain();
        check_eq("nop_w0", 64'(got_q[0]), 64'({1'b1, 32'h0001_0001}));

        // C.LW + C.SW
        do_reset(1);
        got_q.delete();
        send(32'h0084_2483, 1'b0);
        send(32'h0697_AE23, 1'b1);
        drain();
        check_eq("lwsw_w0", 64'(got_q[0]), 64'({1'b1, 32'hDFE4_4404}));

        // Ineligible forms pass through unchanged
        got_q.delete();
        send(32'h0282_8293, 1'b0);
        send(32'h0024_2483, 1'b0);
        send(32'h0002_8293, 1'b1);
        drain();
        check_eq("pass_count", 64'(got_q.size()), 64'd3);
        check_eq("pass_w0", 64'(got_q[0]), 64'({1'b0, 32'h0282_8293}));
        check_eq("pass_w1", 64'(got_q[1]), 64'({1'b0, 32'h0024_2483}));
        check_eq("pass_w2", 64'(got_q[2]), 64'({1'b1, 32'h0002_8293}));

        // Back-pressure: output held for five cycles
        got_q.delete();
        ready_pct = 0;
        idle(1);
        send(32'h1234_50B7, 1'b0);
        fork
            send(32'hABCD_E0B7, 1'b1);
        join_none
        idle(5);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        check_eq("bp_valid", 64'(out_valid), 64'd1);
        check_eq("bp_word", 64'(out_word), 64'h1234_50B7);
        ready_pct = 100;
        drain();
        check_eq("bp_count", 64'(got_q.size()), 64'd2);
        check_eq("bp_w0", 64'(got_q[0]), 64'({1'b0, 32'h1234_50B7}));
        check_eq("bp_w1", 64'(got_q[1]), 64'({1'b1, 32'hABCD_E0B7}));

        // Reset while a halfword is held
        got_q.delete();
        send(32'h0032_8293, 1'b0);
        check_eq("half_pending", 64'(pending), 64'd1);
        do_reset(1);
        check_eq("midrst_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_pending", 64'(pending), 64'd0);
        send(32'h1234_50B7, 1'b1);
        drain();
        check_eq("midrst_count", 64'(got_q.size()), 64'd1);
        check_eq("midrst_w0", 64'(got_q[0]), 64'({1'b1, 32'h1234_50B7}));

        // Randomized traffic with random gaps, block ends and back-pressure
        ready_pct = 70;
        for (int n = 0; n < 600; n++) begin
            idle(int'($urandom_range(3)) == 0 ? int'($urandom_range(2)) : 0);
            send(rand_instr(), (n == 599) || ($urandom_range(5) == 0));
        end
        drain();

        // Full throughput, compressible-heavy
        ready_pct = 100;
        for (int n = 0; n < 200; n++) send(rand_instr(), (n == 199) || ($urandom_range(7) == 0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32c_compress_packer.md
Name: rv32c_compress_packer

Overview:
- Transmit-side counterpart of the RVC decode path: accepts a stream of 32-bit RV32I instructions and compresses eligible ones to 16-bit RVC parcels.
- Packs the resulting mix of 16-bit and 32-bit parcels little-endian into a dense stream of 32-bit memory words.
- Sits between the code-generation/test-stimulus source and instruction memory writer; the output is consumed by the same fetch/align path that feeds the RVC decoder.

Parameters:
- CNT_W, 16, width of statistics counters (optional feature only)
- COMPRESS, 1, 0 = pass-through (never compress; packer still runs)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input instruction valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_instr  in  32  RV32I instruction
- in_last  in  1  last instruction of block; forces flush/pad after it
- out_valid  out  1  packed word valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_word  out  32  packed word, lower halfword = earlier parcel
- out_last  out  1  final word of block
- pending  out  1  a 16-bit parcel is held awaiting a partner

Behaviour:
- Compression rules (combinational on in_instr, gated by COMPRESS); anything else passes as 32-bit:
  - addi x0,x0,0 -> C.NOP 0x0001.
  - addi rd,rd,imm with rd!=0, imm!=0, imm in [-32,31] -> C.ADDI: [15:13]=000, [12]=imm[5], [11:7]=rd, [6:2]=imm[4:0], [1:0]=01.
  - addi rd,x0,imm with rd!=0, imm in [-32,31] -> C.LI: same layout, funct3=010.
  - add rd,x0,rs2 with rd,rs2!=0 -> C.MV: [15:12]=1000, [11:7]=rd, [6:2]=rs2, [1:0]=10.
  - add rd,rd,rs2 with rd,rs2!=0 -> C.ADD: funct4=1001.
  - lw rd,off(rs1) with rd,rs1 in x8..x15, off%4==0, 0<=off<=124 -> C.LW: [15:13]=010, [12:10]=off[5:3], [9:7]=rs1-8, [6]=off[2], [5]=off[6], [4:2]=rd-8, [1:0]=00.
  - sw with the same constraints -> C.SW: funct3=110, [4:2]=rs2-8.
  - add rd,x0,x0 and other RVC HINT/reserved forms are never generated.
- State: EMPTY, HALF (hold[15:0] valid), PAD (must emit {0x0001, hold} with out_last).
- Output is a single registered stage. in_ready = (out_stall==0) && state!=PAD, where out_stall = out_valid && !out_ready.
- Transitions on input accept (parcel c = 16-bit, w = 32-bit):
  - EMPTY+c: hold<=c, go to HALF, no output. If in_last, go to PAD instead of HALF.
  - EMPTY+w: emit w, stay EMPTY, out_last=in_last.
  - HALF+c: emit {c,hold}, go to EMPTY, out_last=in_last.
  - HALF+w: emit {w[15:0],hold}, hold<=w[31:16], stay HALF. If in_last, go to PAD; the emitted word has out_last=0.
  - PAD, when output stage is free: emit {16'h0001,hold} with out_last=1, go to EMPTY.
- Latency: an output word appears one cycle after the accept that completes it. out_word/out_last are stable while out_valid && !out_ready.
- pending = (state!=EMPTY).
- Reset (mid-operation included): state=EMPTY, hold=0, out_valid=0, out_word=0, out_last=0, pending=0. A partial halfword is discarded, never emitted.
- Back-to-back: one word per cycle sustained with out_ready=1. Two compressed inputs produce one word every two cycles.

Optional Feature:
- Macro: RV32C_PACK_STATS_EN.
- With it defined, adds outputs stat_total[CNT_W] (accepted instructions) and stat_compressed[CNT_W] (accepted instructions emitted as 16-bit).
  - Both saturate at all-ones and clear on reset.
- Without it, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- addi x5,x5,3 (0x00328293), lui x1,0x12345 (0x123450B7), add x10,x10,x11 (0x00B50533, last) -> words 0x50B7028D then 0x952E1234 (out_last=1).
- Single addi x0,x0,0 with in_last -> one word 0x00010001, out_last=1; pending returns to 0.
- lw x9,8(x8) (0x00842483) then sw x9,124(x15) (0x0697AE23, last) -> 0xDFE44404, out_last=1, compressed counter=2 with stats enabled.
- Non-eligible forms: addi x5,x5,40; lw with off=2; addi x5,x5,0 -> all pass as 32-bit, three words unchanged.
- out_ready held 0 for 5 cycles with a word pending -> out_word stable, in_ready=0; no input lost and no word duplicated after release.
- Assert reset while in HALF with hold=0x028D -> next cycle out_valid=0, pending=0; the following 32-bit input emits unchanged.
